// File: rtl/ticket_refund_system_if.sv
// Refund channel bundle: sale strobes and refund request in, result and eligibility counts out.
// master = ticketing/host side, slave = refund engine.
interface ticket_refund_system_if;
   logic        sold_vip;
   logic        sold_regular;
   logic        sold_student;
   logic        sold_senior;
   logic        refund_req;
   logic [1:0]  refund_cat;
   logic        refund_ack;
   logic        refund_success;
   logic        refund_failed;
   logic [7:0]  refund_amount;
   logic [7:0]  refundable_vip;
   logic [7:0]  refundable_regular;
   logic [7:0]  refundable_student;
   logic [7:0]  refundable_senior;
   logic [15:0] total_refunded;

   modport master (
      output sold_vip, sold_regular, sold_student, sold_senior,
      output refund_req, refund_cat,
      input  refund_ack, refund_success, refund_failed, refund_amount,
      input  refundable_vip, refundable_regular, refundable_student, refundable_senior,
      input  total_refunded
   );

   modport slave (
      input  sold_vip, sold_regular, sold_student, sold_senior,
      input  refund_req, refund_cat,
      output refund_ack, refund_success, refund_failed, refund_amount,
      output refundable_vip, refundable_regular, refundable_student, refundable_senior,
      output total_refunded
   );
endinterface

// File: rtl/ticket_refund_system.sv
// Ticket refund engine: per-category refundable counters fed by sale strobes, refund FSM.
// Latency: result pulse 2 edges after refund_req is sampled in IDLE; ack from the 3rd edge.
// Backpressure: req/ack level handshake; ack held until refund_req drops, new requests wait for IDLE.
module ticket_refund_system (
   input logic                    clk,
   input logic                    reset,
   ticket_refund_system_if.slave  bus
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] CHECK  = 2'd1;
   localparam logic [1:0] UPDATE = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   logic [1:0]  state;
   logic [1:0]  cat_q;
   logic [7:0]  cnt     [4];
   logic [7:0]  cnt_nxt [4];
   logic [3:0]  sale;
   logic [3:0]  dec;
   logic        hit;
   logic        success_q;
   logic        failed_q;
   logic [7:0]  amount_q;
   logic [15:0] total_q;

   function automatic logic [7:0] price_of(input logic [1:0] c);
      case (c)
         2'd0:    price_of = 8'd100;
         2'd1:    price_of = 8'd50;
         2'd2:    price_of = 8'd30;
         default: price_of = 8'd25;
      endcase
   endfunction

   assign sale = {bus.sold_senior, bus.sold_student, bus.sold_regular, bus.sold_vip};
   assign hit  = (cnt[cat_q] != 8'd0);

   always_comb begin
      dec = 4'b0000;
      if (state == CHECK && hit) dec[cat_q] = 1'b1;
   end

   // A sale and a refund on the same counter cancel, except at saturation where the refund wins.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         cnt_nxt[i] = cnt[i];
         case ({sale[i], dec[i]})
            2'b10:   if (cnt[i] != 8'hff) cnt_nxt[i] = cnt[i] + 8'd1;
            2'b01:   cnt_nxt[i] = cnt[i] - 8'd1;
            2'b11:   if (cnt[i] == 8'hff) cnt_nxt[i] = 8'hfe;
            default: cnt_nxt[i] = cnt[i];
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) cnt[i] <= 8'd0;
      end else begin
         for (int i = 0; i < 4; i++) cnt[i] <= cnt_nxt[i];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cat_q     <= 2'd0;
         success_q <= 1'b0;
         failed_q  <= 1'b0;
         amount_q  <= 8'd0;
         total_q   <= 16'd0;
      end else begin
         success_q <= 1'b0;
         failed_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.refund_req) begin
                  cat_q <= bus.refund_cat;
                  state <= CHECK;
               end
            end
            CHECK: begin
               state <= UPDATE;
               if (hit) begin
                  success_q <= 1'b1;
                  amount_q  <= price_of(cat_q);
                  total_q   <= total_q + {8'd0, price_of(cat_q)};
               end else begin
                  failed_q  <= 1'b1;
                  amount_q  <= 8'd0;
               end
            end
            UPDATE: state <= DONE;
            default: if (!bus.refund_req) state <= IDLE;
         endcase
      end
   end

   assign bus.refund_ack         = (state == DONE);
   assign bus.refund_success     = success_q;
   assign bus.refund_failed      = failed_q;
   assign bus.refund_amount      = amount_q;
   assign bus.total_refunded     = total_q;
   assign bus.refundable_vip     = cnt[0];
   assign bus.refundable_regular = cnt[1];
   assign bus.refundable_student = cnt[2];
   assign bus.refundable_senior  = cnt[3];

endmodule

// File: tb/tb_ticket_refund_system.sv
// Directed and randomized refund scenarios checked against an arithmetic reference model.
module tb_ticket_refund_system;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] sale;
   logic       req;
   logic [1:0] cat;

   always #5 clk = ~clk;

   ticket_refund_system_if bus();

   assign bus.sold_vip     = sale[0];
   assign bus.sold_regular = sale[1];
   assign bus.sold_student = sale[2];
   assign bus.sold_senior  = sale[3];
   assign bus.refund_req   = req;
   assign bus.refund_cat   = cat;

   ticket_refund_system dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int passes = 0;
   int checks = 0;
   int cnt[4];
   int total;
   int amt;
   int price[4] = '{100, 50, 30, 25};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   function automatic logic [7:0] dut_cnt(input int c);
      case (c)
         0:       return bus.refundable_vip;
         1:       return bus.refundable_regular;
         2:       return bus.refundable_student;
         default: return bus.refundable_senior;
      endcase
   endfunction

   task automatic check_state(input string tag);
      for (int c = 0; c < 4; c++) chk($sformatf("%s cnt%0d", tag, c), 32'(dut_cnt(c)), 32'(cnt[c]));
      chk({tag, " total"}, 32'(bus.total_refunded), 32'(total));
      chk({tag, " excl"}, 32'(bus.refund_success & bus.refund_failed), 32'd0);
   endtask

   task automatic model_reset();
      for (int c = 0; c < 4; c++) cnt[c] = 0;
      total = 0;
      amt   = 0;
   endtask

   task automatic check_zero(input string tag);
      check_state(tag);
      chk({tag, " amount"},  32'(bus.refund_amount), 32'd0);
      chk({tag, " ack"},     32'(bus.refund_ack), 32'd0);
      chk({tag, " success"}, 32'(bus.refund_success), 32'd0);
      chk({tag, " failed"},  32'(bus.refund_failed), 32'd0);
   endtask

   // One clock edge: every sold category gains a ticket (capped at 255), a granted refund removes one.
   task automatic step(input int dec_cat);
      @(posedge clk);
      for (int c = 0; c < 4; c++) begin
         int up;
         up = cnt[c] + int'(sale[c]);
         if (up > 255) up = 255;
         cnt[c] = up - ((c == dec_cat) ? 1 : 0);
      end
      #1;
      check_state("step");
   endtask

   task automatic refund(input int c, input logic [3:0] dec_sale, input bit rnd);
      bit ok;
      req  = 1'b1;
      cat  = 2'(c);
      sale = rnd ? 4'($urandom) : 4'b0000;
      step(-1);
      chk("check ack", 32'(bus.refund_ack), 32'd0);
      chk("check pulse", 32'(bus.refund_success | bus.refund_failed), 32'd0);
      ok   = (cnt[c] > 0);
      cat  = 2'($urandom);
      sale = dec_sale;
      if (ok) begin
         total = (total + price[c]) % 65536;
         amt   = price[c];
      end else begin
         amt   = 0;
      end
      step(ok ? c : -1);
      chk("update success", 32'(bus.refund_success), 32'(ok));
      chk("update failed",  32'(bus.refund_failed), 32'(!ok));
      chk("update amount",  32'(bus.refund_amount), 32'(amt));
      chk("update ack",     32'(bus.refund_ack), 32'd0);
      sale = rnd ? 4'($urandom) : 4'b0000;
      cat  = 2'($urandom);
      step(-1);
      chk("done ack",    32'(bus.refund_ack), 32'd1);
      chk("done pulse",  32'(bus.refund_success | bus.refund_failed), 32'd0);
      chk("done amount", 32'(bus.refund_amount), 32'(amt));
      repeat ($urandom_range(0, 2)) begin
         sale = rnd ? 4'($urandom) : 4'b0000;
         step(-1);
         chk("hold ack", 32'(bus.refund_ack), 32'd1);
      end
      req = 1'b0;
      step(-1);
      chk("release ack",    32'(bus.refund_ack), 32'd0);
      chk("release amount", 32'(bus.refund_amount), 32'(amt));
      sale = 4'b0000;
   endtask

   initial begin
      reset = 1'b0;
      sale  = 4'b0000;
      req   = 1'b0;
      cat   = 2'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      reset = 1'b1;

      // VIP sale then refund
      sale = 4'b0001;
      repeat (3) step(-1);
      chk("vip after sales", 32'(bus.refundable_vip), 32'd3);
      sale = 4'b0000;
      refund(0, 4'b0000, 1'b0);
      chk("vip after refund", 32'(bus.refundable_vip), 32'd2);
      chk("vip amount", 32'(bus.refund_amount), 32'd100);
      chk("vip total", 32'(bus.total_refunded), 32'd100);

      // Refund from an empty category
      refund(2, 4'b0000, 1'b0);
      chk("student fail amount", 32'(bus.refund_amount), 32'd0);
      chk("student fail total", 32'(bus.total_refunded), 32'd100);

      // Sale coinciding with the senior decrement
      sale = 4'b1000;
      step(-1);
      sale = 4'b0000;
      refund(3, 4'b1000, 1'b0);
      chk("senior net zero", 32'(bus.refundable_senior), 32'd1);
      chk("senior amount", 32'(bus.refund_amount), 32'd25);

      // Regular saturation, then refund plus sale at the ceiling
      sale = 4'b0010;
      repeat (300) step(-1);
      chk("regular saturated", 32'(bus.refundable_regular), 32'd255);
      sale = 4'b0000;
      refund(1, 4'b0010, 1'b0);
      chk("regular sat refund", 32'(bus.refundable_regular), 32'd254);

      repeat (40) refund($urandom_range(0, 3), 4'($urandom), 1'b1);

      // Reset while the FSM sits in CHECK
      sale = 4'b0001;
      step(-1);
      sale = 4'b0000;
      req  = 1'b1;
      cat  = 2'd0;
      step(-1);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check_zero("async reset");
      req  = 1'b1;
      sale = 4'b1111;
      repeat (3) @(posedge clk);
      #1;
      check_zero("held reset");
      req   = 1'b0;
      sale  = 4'b0100;
      reset = 1'b1;
      step(-1);
      sale = 4'b0000;
      repeat (3) begin
         step(-1);
         chk("post reset pulse", 32'(bus.refund_success | bus.refund_failed), 32'd0);
         chk("post reset ack", 32'(bus.refund_ack), 32'd0);
      end
      chk("first edge sale", 32'(bus.refundable_student), 32'd1);
      refund(2, 4'b0000, 1'b0);
      chk("post reset refund", 32'(bus.refund_amount), 32'd30);

      // 656 VIP refunds from a cleared total
      reset = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      sale  = 4'b0001;
      step(-1);
      sale  = 4'b0000;
      for (int n = 0; n < 656; n++) refund(0, 4'($urandom) | 4'b0001, 1'b1);
      chk("total wrap", 32'(bus.total_refunded), 32'd64);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
